// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace line checker: FSM states, line
// format codes, error bit positions and the grammar's literal characters.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CARET,
        TIME,
        AT,
        PC,
        COLON,
        PREFIX,
        NUM,
        BLANK,
        LT,
        EQ,
        VAL,
        DONE
    } state_t;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    localparam int ERR_PC   = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_REG  = 2;

    localparam logic [3:0]  HEX_DIGITS = 4'd8;
    localparam logic [3:0]  REG_DIGITS = 4'd4;
    localparam logic [13:0] REG_LIMIT  = 14'd32;

    localparam logic [7:0] CH_CARET = "^";
    localparam logic [7:0] CH_AT    = "@";
    localparam logic [7:0] CH_COLON = ":";
    localparam logic [7:0] CH_SPACE = " ";
    localparam logic [7:0] CH_DOLLAR = "$";
    localparam logic [7:0] CH_STAR  = "*";
    localparam logic [7:0] CH_LT    = "<";
    localparam logic [7:0] CH_EQ    = "=";
    localparam logic [7:0] CH_HASH  = "#";

endpackage

// File: rtl/char_classifier.sv
// Combinational character classifier: decimal digit, hex digit and the
// nibble value of the character (0 when it is not a hex digit).
module char_classifier #(
    parameter bit HEX_UPPER = 1'b0
) (
    input  logic [7:0] char,
    output logic       is_digit,
    output logic       is_hex,
    output logic [3:0] nibble
);

    logic is_lower;
    logic is_upper;

    // Classify the character; letters map to 10..15 via their low nibble + 9.
    always_comb begin
        is_digit = (char >= "0") && (char <= "9");
        is_lower = (char >= "a") && (char <= "f");
        is_upper = HEX_UPPER && (char >= "A") && (char <= "F");
        is_hex   = is_digit || is_lower || is_upper;
        nibble   = 4'd0;
        if (is_digit) begin
            nibble = char[3:0];
        end else if (is_lower || is_upper) begin
            nibble = char[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Character-serial checker for CPU trace lines of the form
//   ^time@pc: $reg <= value#   or   ^time@pc: *addr <= value#
// Reports format and range faults for one cycle when a line completes.
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter logic [31:0] PC_MIN      = 32'h0000_3000,
    parameter logic [31:0] PC_MAX      = 32'h0000_6FFC,
    parameter logic [31:0] ADDR_MAX    = 32'h0000_2FFC,
    parameter int          HEX_UPPER   = 0,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [31:0]      pc_out,
    output logic [31:0]      data_out,
    output logic [CNT_W-1:0] line_count,
    output logic [3:0]       dbg_state
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [1:0]  line_type;
    logic [31:0] pc_acc;
    logic [31:0] addr_acc;
    logic [31:0] val_acc;
    logic [13:0] reg_acc;
    logic        is_digit;
    logic        is_hex;
    logic [3:0]  nibble;
    logic        is_reg;
    logic        num_more;
    logic        num_full;
    logic        is_space;

    char_classifier #(
        .HEX_UPPER(HEX_UPPER != 0)
    ) u_class (
        .char    (char),
        .is_digit(is_digit),
        .is_hex  (is_hex),
        .nibble  (nibble)
    );

    assign is_reg    = (line_type == FMT_REG);
    assign is_space  = (char == CH_SPACE);
    // reg takes 1..4 decimal digits, addr exactly 8 hex digits
    assign num_more  = is_reg ? (is_digit && cnt < REG_DIGITS) : (is_hex && cnt < HEX_DIGITS);
    assign num_full  = is_reg ? (cnt != 4'd0) : (cnt == HEX_DIGITS);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: any unexpected character falls back to IDLE, or to CARET on '^'.
    always_comb begin
        next_state = IDLE;
        case (state)
            CARET:  if (is_digit) next_state = TIME;
            TIME:   if (is_digit && cnt < 4'(TIME_DIGITS)) next_state = TIME;
                    else if (char == CH_AT) next_state = AT;
            AT:     if (is_hex) next_state = PC;
            PC:     if (is_hex && cnt < HEX_DIGITS) next_state = PC;
                    else if (char == CH_COLON && cnt == HEX_DIGITS) next_state = COLON;
            COLON:  if (is_space) next_state = COLON;
                    else if (char == CH_DOLLAR || char == CH_STAR) next_state = PREFIX;
            PREFIX: if (is_reg ? is_digit : is_hex) next_state = NUM;
            NUM:    if (num_more) next_state = NUM;
                    else if (num_full && is_space) next_state = BLANK;
                    else if (num_full && char == CH_LT) next_state = LT;
            BLANK:  if (is_space) next_state = BLANK;
                    else if (char == CH_LT) next_state = LT;
            LT:     if (char == CH_EQ) next_state = EQ;
            EQ:     if (is_space) next_state = EQ;
                    else if (is_hex) next_state = VAL;
            VAL:    if (is_hex && cnt < HEX_DIGITS) next_state = VAL;
                    else if (char == CH_HASH && cnt == HEX_DIGITS) next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (next_state == IDLE && char == CH_CARET) begin
            next_state = CARET;
        end
    end

    // Field datapath: digit counter, accumulators and the registered line results.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            line_type  <= FMT_NONE;
            pc_acc     <= 32'd0;
            addr_acc   <= 32'd0;
            val_acc    <= 32'd0;
            reg_acc    <= 14'd0;
            pc_out     <= 32'd0;
            data_out   <= 32'd0;
            line_count <= '0;
        end else begin
            if (next_state == TIME || next_state == PC || next_state == NUM || next_state == VAL) begin
                cnt <= (next_state == state) ? cnt + 4'd1 : 4'd1;
            end else begin
                cnt <= 4'd0;
            end
            if (next_state == CARET) begin
                line_type <= FMT_NONE;
                pc_acc    <= 32'd0;
                addr_acc  <= 32'd0;
                val_acc   <= 32'd0;
                reg_acc   <= 14'd0;
            end
            if (next_state == PC) begin
                pc_acc <= {pc_acc[27:0], nibble};
            end
            if (next_state == PREFIX) begin
                line_type <= (char == CH_DOLLAR) ? FMT_REG : FMT_MEM;
            end
            if (next_state == NUM) begin
                if (is_reg) begin
                    reg_acc <= reg_acc * 14'd10 + 14'(nibble);
                end else begin
                    addr_acc <= {addr_acc[27:0], nibble};
                end
            end
            if (next_state == VAL) begin
                val_acc <= {val_acc[27:0], nibble};
            end
            if (next_state == DONE) begin
                pc_out   <= pc_acc;
                data_out <= val_acc;
                if (line_count != {CNT_W{1'b1}}) begin
                    line_count <= line_count + CNT_W'(1);
                end
            end
        end
    end

    // Line report: only meaningful during the single DONE cycle.
    always_comb begin
        format_type = FMT_NONE;
        error_code  = 4'b0000;
        if (state == DONE) begin
            format_type          = line_type;
            error_code[ERR_PC]   = (pc_acc[1:0] != 2'b00) || (pc_acc < PC_MIN) || (pc_acc > PC_MAX);
            error_code[ERR_ADDR] = (line_type == FMT_MEM) &&
                                   ((addr_acc[1:0] != 2'b00) || (addr_acc > ADDR_MAX));
            error_code[ERR_REG]  = (line_type == FMT_REG) && (reg_acc >= REG_LIMIT);
        end
    end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: two instances (lowercase-only and
// uppercase-hex) share one character stream; completed lines are checked
// against hand-computed expectations queued by the stimulus.
module tb_cpu_trace_checker;

    localparam int CNT_W = 16;
    localparam int EXP_W = 2 + 4 + 32 + 32 + CNT_W;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       char = " ";

    logic [1:0]       ft_a, ft_b;
    logic [3:0]       ec_a, ec_b;
    logic [31:0]      pc_a, pc_b;
    logic [31:0]      dt_a, dt_b;
    logic [CNT_W-1:0] lc_a, lc_b;
    logic [3:0]       st_a, st_b;

    always #5 clk = ~clk;

    cpu_trace_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .char(char),
        .format_type(ft_a), .error_code(ec_a), .pc_out(pc_a),
        .data_out(dt_a), .line_count(lc_a), .dbg_state(st_a)
    );

    cpu_trace_checker #(.HEX_UPPER(1), .CNT_W(CNT_W)) dut_hu (
        .clk(clk), .reset(reset), .char(char),
        .format_type(ft_b), .error_code(ec_b), .pc_out(pc_b),
        .data_out(dt_b), .line_count(lc_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [EXP_W-1:0] exp_a_q[$];
    logic [EXP_W-1:0] exp_b_q[$];
    logic [EXP_W-1:0] e_a, e_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input logic [1:0] fmt, input logic [3:0] err,
                                              input logic [31:0] pc, input logic [31:0] data,
                                              input logic [CNT_W-1:0] lc);
        return {fmt, err, pc, data, lc};
    endfunction

    // Monitor for the lowercase-only instance.
    always @(negedge clk) begin
        if (!reset && ft_a != 2'b00) begin
            if (exp_a_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_line_a: format_type %b error_code %b with nothing expected", ft_a, ec_a);
            end else begin
                e_a = exp_a_q.pop_front();
                check("fmt_a",  32'(ft_a), 32'(e_a[EXP_W-1 -: 2]));
                check("err_a",  32'(ec_a), 32'(e_a[EXP_W-3 -: 4]));
                check("pc_a",   pc_a,      e_a[EXP_W-7 -: 32]);
                check("data_a", dt_a,      e_a[CNT_W+31 -: 32]);
                check("lc_a",   32'(lc_a), 32'(e_a[CNT_W-1:0]));
            end
        end
    end

    // Monitor for the uppercase-hex instance.
    always @(negedge clk) begin
        if (!reset && ft_b != 2'b00) begin
            if (exp_b_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_line_b: format_type %b error_code %b with nothing expected", ft_b, ec_b);
            end else begin
                e_b = exp_b_q.pop_front();
                check("fmt_b",  32'(ft_b), 32'(e_b[EXP_W-1 -: 2]));
                check("err_b",  32'(ec_b), 32'(e_b[EXP_W-3 -: 4]));
                check("pc_b",   pc_b,      e_b[EXP_W-7 -: 32]);
                check("data_b", dt_b,      e_b[CNT_W+31 -: 32]);
                check("lc_b",   32'(lc_b), 32'(e_b[CNT_W-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            char = s[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        char = " ";
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // '^' is presented during reset to confirm it is ignored.
    task automatic do_reset();
        reset = 1'b1;
        char  = "^";
        @(posedge clk);
        #1;
        reset = 1'b0;
        char  = " ";
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        char  = "^";
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        char  = " ";
        @(negedge clk);
        check("rst_fmt",   32'(ft_a), 32'd0);
        check("rst_err",   32'(ec_a), 32'd0);
        check("rst_pc",    pc_a,      32'd0);
        check("rst_data",  dt_a,      32'd0);
        check("rst_lc",    32'(lc_a), 32'd0);
        check("rst_state", 32'(st_a), 32'd0);
        check("rst_lc_b",  32'(lc_b), 32'd0);
        #1;

        // Register write, memory write with misaligned addr, bad pc + bad reg.
        exp_a_q.push_back(pack(2'b01, 4'b0000, 32'h0000_3010, 32'h0000_abcd, 16'd1));
        exp_b_q.push_back(pack(2'b01, 4'b0000, 32'h0000_3010, 32'h0000_abcd, 16'd1));
        send_str("^10@00003010: $3 <= 0000abcd#");
        exp_a_q.push_back(pack(2'b10, 4'b0010, 32'h0000_3004, 32'h1234_5678, 16'd2));
        exp_b_q.push_back(pack(2'b10, 4'b0010, 32'h0000_3004, 32'h1234_5678, 16'd2));
        send_str("^5@00003004:*00000005<=12345678#");
        exp_a_q.push_back(pack(2'b01, 4'b0101, 32'h0000_2ffc, 32'h0000_0000, 16'd3));
        exp_b_q.push_back(pack(2'b01, 4'b0101, 32'h0000_2ffc, 32'h0000_0000, 16'd3));
        send_str("^1@00002ffc: $40 <=00000000#");
        // Max time digits, addr just above ADDR_MAX, extra spaces.
        exp_a_q.push_back(pack(2'b10, 4'b0010, 32'h0000_3000, 32'hffff_ffff, 16'd4));
        exp_b_q.push_back(pack(2'b10, 4'b0010, 32'h0000_3000, 32'hffff_ffff, 16'd4));
        send_str("^9999@00003000:*00003000  <=  ffffffff#");
        // pc at PC_MAX is legal; reg 32 is the first illegal register.
        exp_a_q.push_back(pack(2'b01, 4'b0100, 32'h0000_6ffc, 32'h0000_0000, 16'd5));
        exp_b_q.push_back(pack(2'b01, 4'b0100, 32'h0000_6ffc, 32'h0000_0000, 16'd5));
        send_str("^1@00006ffc:$0032<=00000000#");
        idle(2);

        // Time field one digit too long: first line dropped, second accepted.
        do_reset();
        exp_a_q.push_back(pack(2'b01, 4'b0000, 32'h0000_3000, 32'h0000_0002, 16'd1));
        exp_b_q.push_back(pack(2'b01, 4'b0000, 32'h0000_3000, 32'h0000_0002, 16'd1));
        send_str("^12345@00003000:$1<=00000001#^7@00003000:$1<=00000002#");
        idle(2);

        // Reset mid-line discards the partial line.
        do_reset();
        send_str("^1@0000");
        do_reset();
        send_str("3000:$1<=00000001#");
        idle(2);
        check("midrst_lc",   32'(lc_a), 32'd0);
        check("midrst_pc",   pc_a,      32'd0);
        check("midrst_data", dt_a,      32'd0);
        check("midrst_lc_b", 32'(lc_b), 32'd0);

        // Uppercase hex: only the HEX_UPPER instance accepts it.
        exp_b_q.push_back(pack(2'b01, 4'b0000, 32'h0000_3000, 32'h0000_abcd, 16'd1));
        send_str("^1@00003000:$1<=0000ABCD#");
        idle(1);

        // Back-to-back lines: the second '^' arrives while in DONE.
        exp_a_q.push_back(pack(2'b10, 4'b0000, 32'h0000_6ffc, 32'hdead_beef, 16'd1));
        exp_b_q.push_back(pack(2'b10, 4'b0000, 32'h0000_6ffc, 32'hdead_beef, 16'd2));
        exp_a_q.push_back(pack(2'b01, 4'b0001, 32'h0000_7000, 32'h0000_0001, 16'd2));
        exp_b_q.push_back(pack(2'b01, 4'b0001, 32'h0000_7000, 32'h0000_0001, 16'd3));
        send_str("^2@00006ffc:*00002ffc<=deadbeef#^3@00007000:$31<=00000001#");

        // '^' in the middle of a line restarts it.
        exp_a_q.push_back(pack(2'b01, 4'b0000, 32'h0000_3008, 32'h0000_0003, 16'd3));
        exp_b_q.push_back(pack(2'b01, 4'b0000, 32'h0000_3008, 32'h0000_0003, 16'd4));
        send_str("^1@0000^6@00003008:$2<=00000003#");

        // Malformed lines must leave the outputs untouched.
        send_str("^4@00003000:$1<x=00000001#^4@0000300:$1<=00000001#");
        send_str("^4@00003000:$12345<=00000001#^4@00003000:*0000300<=00000001#");
        send_str("^4@00003000:$1<=0000001#");
        idle(3);
        check("hold_pc",   pc_a,      32'h0000_3008);
        check("hold_data", dt_a,      32'h0000_0003);
        check("hold_lc",   32'(lc_a), 32'd3);
        check("hold_lc_b", 32'(lc_b), 32'd4);

        check("drain_a", 32'(exp_a_q.size()), 32'd0);
        check("drain_b", 32'(exp_b_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the stream is finite, so this only fires if the bench stalls.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/cpu_trace_checker.md
CPU_TRACE_CHECKER -- requirements
Module: cpu_trace_checker

Interface
REQ-001 Parameter TIME_DIGITS, default 4; maximum decimal digits in the time field (1..8).
REQ-002 Parameter PC_MIN, default 32'h0000_3000; lowest legal PC.
REQ-003 Parameter PC_MAX, default 32'h0000_6FFC; highest legal PC.
REQ-004 Parameter ADDR_MAX, default 32'h0000_2FFC; highest legal data address (lowest is 0).
REQ-005 Parameter HEX_UPPER, default 0; when 1, 'A'-'F' are accepted as hex digits as well as 'a'-'f'.
REQ-006 Parameter CNT_W, default 16; width of line_count.
REQ-007 clk  in  1  clock, all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 char  in  8  ASCII character sampled every rising edge.
REQ-010 format_type  out  2  00 none, 01 register write, 10 memory write.
REQ-011 error_code  out  4  bit0 PC fault, bit1 address fault, bit2 register-number fault, bit3 always 0.
REQ-012 pc_out  out  32  PC of the last completed line.
REQ-013 data_out  out  32  write value of the last completed line.
REQ-014 line_count  out  CNT_W  number of well-formed lines completed since reset.

Function
REQ-015 Grammar: '^' time '@' pc ':' sp* ('$' reg | '*' addr) sp* '<' '=' sp* value '#'. sp is ' '.
REQ-016 Field widths: time 1..TIME_DIGITS decimal digits; pc exactly 8 hex digits; reg 1..4 decimal digits; addr exactly 8 hex digits; value exactly 8 hex digits.
REQ-017 FSM states: IDLE, CARET, TIME, AT, PC, COLON, PREFIX, NUM, BLANK, LT, EQ, VAL, DONE. Transitions follow REQ-015. A per-field digit counter enforces REQ-016.
REQ-018 Any character that violates the grammar sends the FSM to IDLE. If that character is '^', the FSM goes to CARET instead (immediate resync). This also applies in DONE.
REQ-019 Hex fields accumulate as value = (value << 4) | nibble. The reg field accumulates in decimal into a 14-bit register. Time is only counted, not stored.
REQ-020 On the edge that samples '#', the FSM enters DONE; format_type and error_code are combinational from DONE and are non-zero only while in DONE, i.e. for exactly one cycle.
REQ-021 Outside DONE, format_type = 00 and error_code = 0000.
REQ-022 pc_out and data_out update on the edge that enters DONE and hold until the next DONE. Partial or aborted lines never change them.
REQ-023 error bit0 is set when pc[1:0] != 0, pc < PC_MIN, or pc > PC_MAX.
REQ-024 error bit1 is set only for type 10, when addr[1:0] != 0 or addr > ADDR_MAX.
REQ-025 error bit2 is set only for type 01, when reg >= 32.
REQ-026 A line carrying an error still counts as well-formed: format_type is non-zero and line_count increments.
REQ-027 line_count increments by 1 on each entry to DONE and saturates at all-ones.

Reset
REQ-028 While reset is high at a rising edge: FSM goes to IDLE; digit counter, type, accumulators, pc_out, data_out and line_count go to 0. char is ignored that cycle.
REQ-029 Reset mid-line discards the partial line. A line is recognised only if its '^' arrives after reset deasserts.

Structure
REQ-030 Package cpu_trace_pkg holds the state enum, format type codes (01/10), and error bit positions.
REQ-031 Sub-module char_classifier (combinational) provides is_digit, is_hex (honouring HEX_UPPER) and a 4-bit nibble value.
REQ-032 Target size is 120-400 lines of RTL; no memories.

Verification
REQ-033 "^10@00003010: $3 <= 0000abcd#" -> one cycle of format_type=01, error_code=0000; pc_out=00003010; data_out=0000abcd; line_count=1.
REQ-034 "^5@00003004:*00000005<=12345678#" -> format_type=10, error_code=0010, data_out=12345678.
REQ-035 "^1@00002ffc: $40 <=00000000#" -> format_type=01, error_code=0101.
REQ-036 TIME_DIGITS=4: "^12345@00003000:$1<=00000001#^7@00003000:$1<=00000002#" -> first line rejected; second line gives format_type=01, data_out=00000002, line_count=1.
REQ-037 Reset high for one cycle after "^1@0000", then "3000:$1<=00000001#" -> no DONE, line_count=0, pc_out=0.
REQ-038 HEX_UPPER=0: "^1@00003000:$1<=0000ABCD#" -> rejected, format_type stays 00; HEX_UPPER=1, same stream -> format_type=01, data_out=0000abcd.
